axi_write_arbiter: RTL and testbench

- Shares the single DDR3 AXI write port (c0_s1_axi_aw*/w*/b*) among up to 4 engine write requesters. It is the write-side counterpart of the read arbiter.
- Round-robin grant per burst. Runs one write transaction at a time: address phase, data burst, then response.
- Each requester sees a simple info/data valid-ready interface and receives a completion pulse.
- Sits between the engines' result writers and the Pico AXI master port, in the sys_clk domain.

---
 rtl/axi_write_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_axi_write_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_arbiter.sv
// -----------------------------------------------------------------------------
// axi_write_arbiter
//   Shares one AXI write port (AW/W/B) among four requesters. The arbiter grants
//   one requester per burst in round-robin order. It runs one transaction at a
//   time: the address phase, then the data burst, then the response.
//
// Ports
//   clk, rst               : system clock, asynchronous active-low reset
//   active_ports_in        : per-port enable mask; only sampled when granting
//   wr_id_in/addr/len      : packed per-port burst descriptors (port p at slice p)
//   wr_info_valid/rdy      : per-port descriptor handshake (rdy is one-hot)
//   wr_data_in/valid/rdy   : per-port write-data stream
//   wr_done_out/wr_err_out : one-cycle completion pulse and its error qualifier
//   axi_aw*/axi_w*/axi_b*  : AXI write master channels
// -----------------------------------------------------------------------------
module axi_write_arbiter #(
    parameter int ADDR_WIDTH = 33,
    parameter int DATA_WIDTH = 256,
    parameter int ID_WIDTH   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [3:0]                  active_ports_in,
    input  logic [4*(ID_WIDTH-2)-1:0]   wr_id_in,
    input  logic [4*ADDR_WIDTH-1:0]     wr_addr_in,
    input  logic [4*8-1:0]              wr_len_in,
    input  logic [3:0]                  wr_info_valid_in,
    output logic [3:0]                  wr_info_rdy_out,
    input  logic [4*DATA_WIDTH-1:0]     wr_data_in,
    input  logic [3:0]                  wr_data_valid_in,
    output logic [3:0]                  wr_data_rdy_out,
    output logic [3:0]                  wr_done_out,
    output logic                        wr_err_out,
    input  logic                        axi_awready_in,
    output logic [ID_WIDTH-1:0]         axi_awid_out,
    output logic [ADDR_WIDTH-1:0]       axi_awaddr_out,
    output logic [7:0]                  axi_awlen_out,
    output logic                        axi_awvalid_out,
    input  logic                        axi_wready_in,
    output logic [DATA_WIDTH-1:0]       axi_wdata_out,
    output logic                        axi_wlast_out,
    output logic                        axi_wvalid_out,
    input  logic                        axi_bvalid_in,
    input  logic [1:0]                  axi_bresp_in,
    output logic                        axi_bready_out
);

    localparam int IDW = ID_WIDTH - 2;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [1:0]             r_grant;
    logic [1:0]             r_last_grant;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [7:0]             r_len;
    logic [ID_WIDTH-1:0]    r_id;
    logic [7:0]             r_beat;
    logic [3:0]             r_done;
    logic                   r_err;

    logic [ADDR_WIDTH-1:0]  w_addr [4];
    logic [7:0]             w_len  [4];
    logic [IDW-1:0]         w_id   [4];
    logic [DATA_WIDTH-1:0]  w_data [4];

    logic [3:0]             w_req;
    logic [1:0]             w_winner;
    logic [1:0]             w_cand;
    logic                   w_found;
    logic                   w_last;
    logic                   w_w_hs;

    // Unpack the per-port buses into arrays indexed by port.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_unpack
            assign w_addr[gi] = wr_addr_in[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_len[gi]  = wr_len_in[gi*8 +: 8];
            assign w_id[gi]   = wr_id_in[gi*IDW +: IDW];
            assign w_data[gi] = wr_data_in[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign w_req = wr_info_valid_in & active_ports_in;

    // Round-robin search. Candidates are scanned from offset 4 down to offset 1,
    // so the nearest port after last_grant is written last and wins. Offset 4
    // is last_grant itself, so that port has the lowest priority.
    always_comb begin
        w_winner = 2'd0;
        w_found  = 1'b0;
        w_cand   = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            w_cand = r_last_grant + 2'(k);
            if (w_req[w_cand]) begin
                w_winner = w_cand;
                w_found  = 1'b1;
            end
        end
    end

    assign w_last = (r_beat == r_len);
    assign w_w_hs = (r_state == S_DATA) && wr_data_valid_in[r_grant] && axi_wready_in;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_found)        w_state_next = S_ADDR;
            S_ADDR: if (axi_awready_in) w_state_next = S_DATA;
            S_DATA: if (w_w_hs && w_last) w_state_next = S_RESP;
            S_RESP: if (axi_bvalid_in)  w_state_next = S_IDLE;
            default:                    w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        wr_info_rdy_out = 4'b0000;
        wr_data_rdy_out = 4'b0000;
        axi_awvalid_out = 1'b0;
        axi_wvalid_out  = 1'b0;
        axi_wlast_out   = 1'b0;
        axi_bready_out  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // The state register already sits at IDLE while reset is held.
                // Gating with rst keeps the descriptor handshake quiet then.
                if (w_found && rst) wr_info_rdy_out = 4'b0001 << w_winner;
            end
            S_ADDR: axi_awvalid_out = 1'b1;
            S_DATA: begin
                axi_wvalid_out  = wr_data_valid_in[r_grant];
                wr_data_rdy_out = {3'b000, axi_wready_in} << r_grant;
                axi_wlast_out   = w_last;
            end
            S_RESP: axi_bready_out = 1'b1;
            default: ;
        endcase
    end

    assign axi_awid_out   = r_id;
    assign axi_awaddr_out = r_addr;
    assign axi_awlen_out  = r_len;
    assign axi_wdata_out  = w_data[r_grant];
    assign wr_done_out    = r_done;
    assign wr_err_out     = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_grant      <= 2'd0;
            r_last_grant <= 2'd3;
            r_addr       <= '0;
            r_len        <= 8'd0;
            r_id         <= '0;
            r_beat       <= 8'd0;
            r_done       <= 4'b0000;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 4'b0000;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant      <= w_winner;
                        r_last_grant <= w_winner;
                        r_addr       <= w_addr[w_winner];
                        r_len        <= w_len[w_winner];
                        r_id         <= {w_winner, w_id[w_winner]};
                    end
                end
                S_ADDR: begin
                    if (axi_awready_in) r_beat <= 8'd0;
                end
                S_DATA: begin
                    // The beat counter clears on the last beat, so len=255 never wraps.
                    if (w_w_hs) r_beat <= w_last ? 8'd0 : r_beat + 8'd1;
                end
                S_RESP: begin
                    if (axi_bvalid_in) begin
                        r_done <= 4'b0001 << r_grant;
                        r_err  <= |axi_bresp_in;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_arbiter.sv
module tb_axi_write_arbiter;

    localparam int AW = 33;
    localparam int DW = 256;
    localparam int IW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [3:0]      active_ports_in = '0;
    logic [4*6-1:0]  wr_id_in = '0;
    logic [4*AW-1:0] wr_addr_in = '0;
    logic [31:0]     wr_len_in = '0;
    logic [3:0]      wr_info_valid_in = '0;
    logic [3:0]      wr_info_rdy_out;
    logic [4*DW-1:0] wr_data_in = '0;
    logic [3:0]      wr_data_valid_in = '0;
    logic [3:0]      wr_data_rdy_out;
    logic [3:0]      wr_done_out;
    logic            wr_err_out;
    logic            axi_awready_in = 1'b0;
    logic [IW-1:0]   axi_awid_out;
    logic [AW-1:0]   axi_awaddr_out;
    logic [7:0]      axi_awlen_out;
    logic            axi_awvalid_out;
    logic            axi_wready_in = 1'b0;
    logic [DW-1:0]   axi_wdata_out;
    logic            axi_wlast_out;
    logic            axi_wvalid_out;
    logic            axi_bvalid_in = 1'b0;
    logic [1:0]      axi_bresp_in = 2'b00;
    logic            axi_bready_out;

    always #5 clk = ~clk;

    axi_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .active_ports_in(active_ports_in),
        .wr_id_in(wr_id_in), .wr_addr_in(wr_addr_in), .wr_len_in(wr_len_in),
        .wr_info_valid_in(wr_info_valid_in), .wr_info_rdy_out(wr_info_rdy_out),
        .wr_data_in(wr_data_in), .wr_data_valid_in(wr_data_valid_in),
        .wr_data_rdy_out(wr_data_rdy_out),
        .wr_done_out(wr_done_out), .wr_err_out(wr_err_out),
        .axi_awready_in(axi_awready_in), .axi_awid_out(axi_awid_out),
        .axi_awaddr_out(axi_awaddr_out), .axi_awlen_out(axi_awlen_out),
        .axi_awvalid_out(axi_awvalid_out),
        .axi_wready_in(axi_wready_in), .axi_wdata_out(axi_wdata_out),
        .axi_wlast_out(axi_wlast_out), .axi_wvalid_out(axi_wvalid_out),
        .axi_bvalid_in(axi_bvalid_in), .axi_bresp_in(axi_bresp_in),
        .axi_bready_out(axi_bready_out)
    );

    // Requester-side model: pending burst count plus the current descriptor per port.
    int            pend   [4];
    logic [AW-1:0] f_addr [4];
    logic [7:0]    f_len  [4];
    logic [5:0]    f_id   [4];
    logic [DW-1:0] f_base [4];
    int            lg_m;        // port most recently granted
    int            checks   = 0;
    int            failures = 0;
    int            txn_no   = 0;

    task automatic chk(input string tag, input logic [259:0] obs, input logic [259:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s txn=%0d observed=%0h expected=%0h", tag, txn_no, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive_info();
        for (int p = 0; p < 4; p++) begin
            wr_id_in[p*6 +: 6]    = f_id[p];
            wr_addr_in[p*AW +: AW] = f_addr[p];
            wr_len_in[p*8 +: 8]   = f_len[p];
            wr_info_valid_in[p]   = (pend[p] > 0);
        end
    endtask

    task automatic refresh(input int p);
        f_id[p]   = 6'($urandom);
        f_base[p] = rand256();
        f_addr[p] = f_addr[p] + 33'h40;
    endtask

    // Round-robin rule: nearest requesting port after the last grant, modulo 4.
    function automatic int model_winner(input logic [3:0] req);
        for (int k = 1; k <= 4; k++) begin
            if (req[(lg_m + k) % 4]) return (lg_m + k) % 4;
        end
        return -1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_awvalid"}, 260'(axi_awvalid_out), 260'(0));
        chk({tag, "_wvalid"},  260'(axi_wvalid_out),  260'(0));
        chk({tag, "_wlast"},   260'(axi_wlast_out),   260'(0));
        chk({tag, "_bready"},  260'(axi_bready_out),  260'(0));
        chk({tag, "_info_rdy"}, 260'(wr_info_rdy_out), 260'(0));
        chk({tag, "_data_rdy"}, 260'(wr_data_rdy_out), 260'(0));
        chk({tag, "_done"},    260'(wr_done_out),     260'(0));
        chk({tag, "_err"},     260'(wr_err_out),      260'(0));
        chk({tag, "_awaddr"},  260'(axi_awaddr_out),  260'(0));
        chk({tag, "_awlen"},   260'(axi_awlen_out),   260'(0));
        chk({tag, "_awid"},    260'(axi_awid_out),    260'(0));
    endtask

    task automatic init_model();
        lg_m = 3;
        for (int p = 0; p < 4; p++) begin
            pend[p]   = 0;
            f_len[p]  = 8'd0;
            f_addr[p] = 33'(p) << 24;
            refresh(p);
        end
    endtask

    // One transaction in lockstep with the DUT. Entered shortly after a falling edge.
    // exp_port >= 0 forces the expected winner (directed tests); rst_at >= 0 asserts
    // reset asynchronously when that beat is reached.
    task automatic do_txn(input logic [3:0] mask, input int awdel, input int mode,
                          input logic [1:0] bresp, input int rst_at, input int exp_port);
        int g, b, budget, drop, bdel;
        bit dropped, dv, wr;
        logic [3:0] req;
        logic [AW-1:0] e_addr;
        logic [7:0] e_len;
        logic [IW-1:0] e_id;
        logic [DW-1:0] e_base;
        txn_no++;
        active_ports_in = mask;
        drive_info();
        #1;
        req = wr_info_valid_in & mask;
        g = model_winner(req);
        if (exp_port >= 0) g = exp_port;
        if (g < 0) begin
            chk("no_req_rdy", 260'(wr_info_rdy_out), 260'(0));
            return;
        end
        chk("info_rdy", 260'(wr_info_rdy_out), 260'(4'b0001 << g));
        e_addr = f_addr[g];
        e_len  = f_len[g];
        e_id   = {2'(g), f_id[g]};
        e_base = f_base[g];
        @(posedge clk);
        pend[g]--;
        lg_m = g;
        @(negedge clk);
        refresh(g);
        drive_info();
        // Address phase; stray bvalid here must be ignored.
        for (int i = 0; i <= awdel; i++) begin
            axi_awready_in = (i == awdel);
            axi_bvalid_in  = 1'($urandom);
            #1;
            chk("awvalid", 260'(axi_awvalid_out), 260'(1));
            chk("awaddr",  260'(axi_awaddr_out),  260'(e_addr));
            chk("awlen",   260'(axi_awlen_out),   260'(e_len));
            chk("awid",    260'(axi_awid_out),    260'(e_id));
            if (i == 0) chk("info_rdy_busy", 260'(wr_info_rdy_out), 260'(0));
            @(posedge clk);
            @(negedge clk);
        end
        axi_awready_in = 1'b0;
        axi_bvalid_in  = 1'b0;
        // Data phase.
        b = 0; budget = 0; drop = 0; dropped = 0;
        while (b <= int'(e_len) && budget < 5000) begin
            budget++;
            if (rst_at >= 0 && b == rst_at) begin
                #2 rst = 1'b0;
                #1 chk_all_zero("async_rst");
                return;
            end
            if (mode == 1) begin
                wr = (budget % 2 == 0);
                if (b == 100 && !dropped) begin drop = 3; dropped = 1; end
                dv = (drop == 0);
                if (drop > 0) drop--;
            end else begin
                wr = ($urandom % 4 != 0);
                dv = ($urandom % 4 != 0);
                active_ports_in = 4'($urandom);
                axi_bvalid_in   = 1'($urandom);
            end
            for (int p = 0; p < 4; p++) begin
                wr_data_in[p*DW +: DW] = rand256();
                wr_data_valid_in[p]    = 1'($urandom);
            end
            wr_data_in[g*DW +: DW] = e_base ^ DW'(b);
            wr_data_valid_in[g]    = dv;
            axi_wready_in          = wr;
            #1;
            chk("wvalid",   260'(axi_wvalid_out),  260'(dv));
            chk("wdata",    260'(axi_wdata_out),   260'(e_base ^ DW'(b)));
            chk("wlast",    260'(axi_wlast_out),   260'(b == int'(e_len)));
            chk("data_rdy", 260'(wr_data_rdy_out), 260'(wr ? (4'b0001 << g) : 4'b0000));
            chk("done_idle", 260'(wr_done_out),    260'(0));
            @(posedge clk);
            if (dv && wr) b++;
            @(negedge clk);
        end
        if (b <= int'(e_len)) begin
            chk("beat_budget", 260'(b), 260'(int'(e_len) + 1));
            return;
        end
        axi_wready_in    = 1'b0;
        wr_data_valid_in = 4'b0000;
        // Response phase.
        bdel = $urandom % 3;
        for (int i = 0; i <= bdel; i++) begin
            axi_bvalid_in = (i == bdel);
            axi_bresp_in  = (i == bdel) ? bresp : 2'($urandom);
            #1;
            chk("bready", 260'(axi_bready_out), 260'(1));
            chk("wvalid_resp", 260'(axi_wvalid_out), 260'(0));
            chk("done_early", 260'(wr_done_out), 260'(0));
            @(posedge clk);
            @(negedge clk);
        end
        axi_bvalid_in = 1'b0;
        axi_bresp_in  = 2'b00;
        #1;
        chk("done", 260'(wr_done_out), 260'(4'b0001 << g));
        chk("err",  260'(wr_err_out),  260'(bresp != 2'b00));
        chk("bready_off", 260'(axi_bready_out), 260'(0));
        $display("txn %0d port=%0d len=%0d addr=%0h bresp=%0d checks=%0d failures=%0d",
                 txn_no, g, e_len, e_addr, bresp, checks, failures);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        active_ports_in  = 4'b0000;
        wr_data_valid_in = 4'b0000;
        axi_awready_in = 1'b0;
        axi_wready_in  = 1'b0;
        axi_bvalid_in  = 1'b0;
        init_model();
        drive_info();
        repeat (2) @(negedge clk);
        #1 chk_all_zero("in_rst");
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        // Reset with idle inputs, then a masked-off request must not be granted.
        do_reset();
        chk_all_zero("post_rst");
        pend[0] = 1;
        do_txn(4'b0000, 0, 0, 2'b00, -1, -1);
        pend[0] = 0;
        // Port 2 alone: awid carries port index 2 in the top bits.
        pend[2] = 1; f_len[2] = 8'd2;
        do_txn(4'hF, 1, 0, 2'b00, -1, 2);

        // All four ports requesting continuously, len=3: strict rotation 0,1,2,3,0.
        do_reset();
        for (int p = 0; p < 4; p++) begin pend[p] = (p == 0) ? 2 : 1; f_len[p] = 8'd3; end
        do_txn(4'hF, 0, 0, 2'b00, -1, 0);
        do_txn(4'hF, 0, 0, 2'b00, -1, 1);
        do_txn(4'hF, 0, 0, 2'b00, -1, 2);
        do_txn(4'hF, 0, 0, 2'b00, -1, 3);
        do_txn(4'hF, 0, 0, 2'b00, -1, 0);

        // Port 1, single beat, awready held off for 5 cycles.
        pend[1] = 1; f_len[1] = 8'd0; f_addr[1] = 33'h100;
        do_txn(4'hF, 5, 0, 2'b00, -1, 1);

        // Port 3, 256 beats with wready toggling and a 3-cycle data_valid drop.
        pend[3] = 1; f_len[3] = 8'd255;
        do_txn(4'hF, 0, 1, 2'b00, -1, 3);

        // Error response on port 0, then a clean response on port 1.
        pend[0] = 1; f_len[0] = 8'd1;
        pend[1] = 1; f_len[1] = 8'd2;
        do_txn(4'hF, 0, 0, 2'b10, -1, 0);
        do_txn(4'hF, 0, 0, 2'b00, -1, 1);

        // Port 2 reset asynchronously at beat 10; afterwards port 0 has priority.
        pend[2] = 1; f_len[2] = 8'd20;
        do_txn(4'hF, 0, 0, 2'b00, 10, 2);
        @(negedge clk);
        #1 chk_all_zero("rst_hold");
        @(negedge clk);
        rst = 1'b1;
        init_model();
        for (int p = 0; p < 4; p++) begin pend[p] = 1; f_len[p] = 8'd1; end
        wr_data_valid_in = 4'b0000;
        axi_wready_in    = 1'b0;
        axi_bvalid_in    = 1'b0;
        do_txn(4'hF, 0, 0, 2'b00, -1, 0);

        // Randomized traffic against the round-robin model.
        for (int n = 0; n < 25; n++) begin
            logic [3:0] mask, vld;
            int any;
            any = 0;
            for (int p = 0; p < 4; p++) begin
                if (pend[p] == 0 && ($urandom % 2) == 1) begin
                    pend[p]  = 1 + int'($urandom % 2);
                    f_len[p] = 8'($urandom % 16);
                end
                any += pend[p];
            end
            if (any == 0) begin
                pend[$urandom % 4] = 1;
            end
            for (int p = 0; p < 4; p++) vld[p] = (pend[p] > 0);
            mask = 4'($urandom);
            if ((mask & vld) == 4'b0000) mask = 4'hF;
            do_txn(mask, int'($urandom % 3), 0, 2'($urandom), -1, -1);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute guard so the run always ends on its own.
    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
